reg_file_mp: RTL and testbench
==============================

Name: reg_file_mp

Overview:
- Parametrised multi-port register file for the next pipeline generation.
- Generalises the 32x32 single-write file with:
  - configurable width, depth and read-port count
  - two write ports with fixed priority
  - same-cycle write-to-read bypass
  - optional hardwired zero register
  - synchronous active-low clear
  - an integrated pending-write scoreboard used by hazard detection
- Sits between decode (read/issue) and writeback (write ports).

Parameters:
- DW, 32, data width in bits
- DEPTH, 32, number of registers (power of two, >= 2)
- AW, $clog2(DEPTH), address width (derived, not overridden)
- NUM_RD, 3, number of read ports (1..4)
- ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes/issues
- BYPASS, 1, 1 = read ports return same-cycle write data

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- rd_addr  in  NUM_RD*AW  read addresses, port k at [k*AW +: AW]
- rd_data  out  NUM_RD*DW  read data, port k at [k*DW +: DW]
- rd_busy  out  NUM_RD  port k: register has an outstanding write (after bypass)
- wr0_en  in  1  write port 0 enable
- wr0_addr  in  AW  write port 0 address
- wr0_data  in  DW  write port 0 data
- wr1_en  in  1  write port 1 enable (higher priority)
- wr1_addr  in  AW  write port 1 address
- wr1_data  in  DW  write port 1 data
- iss_en  in  1  mark iss_addr as pending producer
- iss_addr  in  AW  destination register being issued
- flush  in  1  clear all pending bits (pipeline squash)
- busy_vec  out  DEPTH  registered pending bit per register

Behaviour:
- Reset (rst_n=0 at rising edge): all registers = 0, all busy bits = 0.
  - During reset, reads return stored (zero) values.
  - rst_n has priority over flush, writes and issues in the same cycle.
- Writes take effect at the rising edge.
  - wr0 and wr1 to the same address in the same cycle: wr1 data stored.
  - Different addresses: both stored.
- Reads are combinational (zero latency).
  - BYPASS=1, rd_addr==wrN_addr with wrN_en: returns wrN_data, wr1 over wr0.
  - Otherwise returns the stored value.
  - BYPASS=0: always returns the stored value; the new value is visible the cycle after the edge.
- ZERO_REG=1, address 0:
  - reads return 0, including under bypass
  - writes discarded
  - iss_en ignored
  - busy[0] always 0
- Scoreboard, per register, evaluated at the edge:
  - flush=1: all busy cleared, then this cycle's iss_en applied (issue survives flush).
  - Else, write to r (either port): busy[r] cleared.
  - iss_en to r: busy[r] set.
  - Issue and write to the same r in the same cycle: busy[r] ends 1 (new producer wins).
- rd_busy[k]:
  - = busy[rd_addr_k] & ~(BYPASS & matching same-cycle write)
  - forced 0 for address 0 when ZERO_REG=1
- Address range: indices are always in range because DEPTH is a power of two; no wrap handling needed.
- busy_vec is a direct register output with no combinational path from inputs.

Decomposition:
- Shared package rf_pkg:
  - default DW/DEPTH/NUM_RD constants
  - a function computing the bypass select for one read port, reused by hazard logic elsewhere
- Natural sub-module: rf_scoreboard (DEPTH busy flops; iss/flush/write-clear logic), instantiated once.
- Data array and bypass muxes stay in reg_file_mp via a generate loop over NUM_RD.

Test Plan:
- Reset clear: pre-load r5=0xDEADBEEF, hold rst_n=0 one edge → all rd_data read 0, busy_vec=0.
- Dual-write priority: wr0 and wr1 both to r7, data 0x11 and 0x22 → r7 reads 0x22 next cycle; r8 via wr0 in the same cycle also stored.
- Bypass:
  - BYPASS=1, write r3=0xA5A5 while rd_addr0=3 → rd_data0=0xA5A5 in the same cycle.
  - BYPASS=0 → old value that cycle, 0xA5A5 the next.
- Zero register: write r0=0xFFFFFFFF and iss_en to r0 → rd_data for r0=0, busy_vec[0]=0.
- Scoreboard:
  - iss r9 → busy_vec[9]=1, rd_busy=1.
  - Write r9 (BYPASS=1) → rd_busy=0 that cycle, busy_vec[9]=0 after the edge.
  - Simultaneous iss r9 and write r9 → busy_vec[9]=1.
- Flush: busy set on r2, r4; flush with iss r6 → busy_vec has only bit 6 set.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared register-file definitions: default geometry and the per-port bypass
// select function, also used by hazard logic outside this block.
package rf_pkg;

    localparam int RF_DW     = 32;
    localparam int RF_DEPTH  = 32;
    localparam int RF_NUM_RD = 3;
    localparam int RF_MAX_AW = 16;

    typedef enum logic [1:0] {
        RF_SEL_MEM = 2'd0,
        RF_SEL_WR0 = 2'd1,
        RF_SEL_WR1 = 2'd2
    } rf_sel_e;

    // Addresses are zero-extended to RF_MAX_AW by the caller; wr1 outranks wr0.
    function automatic rf_sel_e rf_bypass_sel(
        input logic [RF_MAX_AW-1:0] rd_addr,
        input logic                 wr0_en,
        input logic [RF_MAX_AW-1:0] wr0_addr,
        input logic                 wr1_en,
        input logic [RF_MAX_AW-1:0] wr1_addr
    );
        rf_sel_e sel;
        sel = RF_SEL_MEM;
        if (wr0_en && (wr0_addr == rd_addr)) sel = RF_SEL_WR0;
        if (wr1_en && (wr1_addr == rd_addr)) sel = RF_SEL_WR1;
        return sel;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one busy flop per register, set on issue and
// cleared by writeback or a pipeline flush.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter  int DEPTH = RF_DEPTH,
    localparam int AW    = $clog2(DEPTH)
)(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_wr0_en,
    input  logic [AW-1:0]    i_wr0_addr,
    input  logic             i_wr1_en,
    input  logic [AW-1:0]    i_wr1_addr,
    input  logic             i_iss_en,
    input  logic [AW-1:0]    i_iss_addr,
    input  logic             i_flush,
    output logic [DEPTH-1:0] o_busy
);

    logic [DEPTH-1:0] r_busy;
    logic [DEPTH-1:0] w_busy_next;

    // Issue is applied last so a new producer survives both flush and writeback.
    always_comb begin
        w_busy_next = r_busy;
        if (i_flush) begin
            w_busy_next = '0;
        end else begin
            if (i_wr0_en) w_busy_next[i_wr0_addr] = 1'b0;
            if (i_wr1_en) w_busy_next[i_wr1_addr] = 1'b0;
        end
        if (i_iss_en) w_busy_next[i_iss_addr] = 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_next;
        end
    end

    assign o_busy = r_busy;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file: two prioritised write ports, NUM_RD combinational
// read ports with optional same-cycle bypass, optional zero register, busy tracking.
module reg_file_mp
    import rf_pkg::*;
#(
    parameter  int DW       = RF_DW,
    parameter  int DEPTH    = RF_DEPTH,
    parameter  int NUM_RD   = RF_NUM_RD,
    parameter  bit ZERO_REG = 1'b1,
    parameter  bit BYPASS   = 1'b1,
    localparam int AW       = $clog2(DEPTH)
)(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_RD*AW-1:0] rd_addr,
    output logic [NUM_RD*DW-1:0] rd_data,
    output logic [NUM_RD-1:0]    rd_busy,
    input  logic                 wr0_en,
    input  logic [AW-1:0]        wr0_addr,
    input  logic [DW-1:0]        wr0_data,
    input  logic                 wr1_en,
    input  logic [AW-1:0]        wr1_addr,
    input  logic [DW-1:0]        wr1_data,
    input  logic                 iss_en,
    input  logic [AW-1:0]        iss_addr,
    input  logic                 flush,
    output logic [DEPTH-1:0]     busy_vec
);

    logic [DW-1:0]    r_mem [DEPTH];
    logic             w_wr0_en;
    logic             w_wr1_en;
    logic             w_iss_en;
    logic [DEPTH-1:0] w_busy;

    // Accesses to r0 are dropped here; reset also hides writes from the bypass path.
    assign w_wr0_en = wr0_en && rst_n && !(ZERO_REG && (wr0_addr == '0));
    assign w_wr1_en = wr1_en && rst_n && !(ZERO_REG && (wr1_addr == '0));
    assign w_iss_en = iss_en && !(ZERO_REG && (iss_addr == '0));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_wr0_en) r_mem[wr0_addr] <= wr0_data;
            if (w_wr1_en) r_mem[wr1_addr] <= wr1_data;
        end
    end

    rf_scoreboard #(
        .DEPTH (DEPTH)
    ) u_scoreboard (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_wr0_en   (w_wr0_en),
        .i_wr0_addr (wr0_addr),
        .i_wr1_en   (w_wr1_en),
        .i_wr1_addr (wr1_addr),
        .i_iss_en   (w_iss_en),
        .i_iss_addr (iss_addr),
        .i_flush    (flush),
        .o_busy     (w_busy)
    );

    assign busy_vec = w_busy;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [AW-1:0] w_addr;
        logic          w_is_zero;
        rf_sel_e       w_sel;
        logic [DW-1:0] w_data;
        logic          w_bypassed;

        assign w_addr    = rd_addr[k*AW +: AW];
        assign w_is_zero = ZERO_REG && (w_addr == '0);

        always_comb begin
            w_sel = rf_bypass_sel(RF_MAX_AW'(w_addr), w_wr0_en, RF_MAX_AW'(wr0_addr),
                                  w_wr1_en, RF_MAX_AW'(wr1_addr));
        end

        assign w_bypassed = BYPASS && (w_sel != RF_SEL_MEM);

        always_comb begin
            w_data = r_mem[w_addr];
            if (BYPASS) begin
                case (w_sel)
                    RF_SEL_WR0: w_data = wr0_data;
                    RF_SEL_WR1: w_data = wr1_data;
                    default:    w_data = r_mem[w_addr];
                endcase
            end
            if (w_is_zero) w_data = '0;
        end

        assign rd_data[k*DW +: DW] = w_data;
        assign rd_busy[k]          = w_busy[w_addr] && !w_bypassed && !w_is_zero;
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: a bypassing and a non-bypassing instance
// share all inputs and are checked against hand-computed values.
module tb_reg_file_mp;

    localparam int DW     = 32;
    localparam int DEPTH  = 32;
    localparam int AW     = 5;
    localparam int NUM_RD = 3;
    localparam int NVEC   = 18;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NUM_RD*AW-1:0] rd_addr;
    logic [NUM_RD*DW-1:0] rd_data_byp, rd_data_nob;
    logic [NUM_RD-1:0]    rd_busy_byp, rd_busy_nob;
    logic                 wr0_en, wr1_en, iss_en, flush;
    logic [AW-1:0]        wr0_addr, wr1_addr, iss_addr;
    logic [DW-1:0]        wr0_data, wr1_data;
    logic [DEPTH-1:0]     busy_vec_byp, busy_vec_nob;

    int total = 0;
    int bad   = 0;
    logic [DW-1:0] exp_q[$];

    always #5 clk = ~clk;

    reg_file_mp #(.DW(DW), .DEPTH(DEPTH), .NUM_RD(NUM_RD), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_dut_byp (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_byp), .rd_busy(rd_busy_byp),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush), .busy_vec(busy_vec_byp)
    );

    reg_file_mp #(.DW(DW), .DEPTH(DEPTH), .NUM_RD(NUM_RD), .ZERO_REG(1'b1), .BYPASS(1'b0)) u_dut_nob (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_nob), .rd_busy(rd_busy_nob),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush), .busy_vec(busy_vec_nob)
    );

    typedef struct {
        logic          w0;  logic [AW-1:0] a0; logic [DW-1:0] d0;
        logic          w1;  logic [AW-1:0] a1; logic [DW-1:0] d1;
        logic          iss; logic [AW-1:0] ia;
        logic          fl;  logic [AW-1:0] ra;
        logic [DW-1:0] e_byp;   // port 0 data before the edge, BYPASS=1
        logic [DW-1:0] e_nob;   // port 0 data before the edge, BYPASS=0
        logic          eb_byp;  // port 0 busy before the edge, BYPASS=1
        logic          eb_nob;  // port 0 busy before the edge, BYPASS=0
        logic [DW-1:0] e_vec;   // busy_vec after the edge (both instances)
    } vec_t;

    vec_t vt[NVEC];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        wr0_en = 1'b0; wr0_addr = '0; wr0_data = '0;
        wr1_en = 1'b0; wr1_addr = '0; wr1_data = '0;
        iss_en = 1'b0; iss_addr = '0; flush = 1'b0;
        rd_addr = '0;
    endtask

    task automatic run_vec(input int i, input vec_t v);
        wr0_en = v.w0;  wr0_addr = v.a0; wr0_data = v.d0;
        wr1_en = v.w1;  wr1_addr = v.a1; wr1_data = v.d1;
        iss_en = v.iss; iss_addr = v.ia; flush = v.fl;
        rd_addr = {10'd0, v.ra};
        #2;
        check($sformatf("v%0d rd_data_byp", i), rd_data_byp[DW-1:0], v.e_byp);
        check($sformatf("v%0d rd_data_nob", i), rd_data_nob[DW-1:0], v.e_nob);
        check($sformatf("v%0d rd_busy_byp", i), {31'd0, rd_busy_byp[0]}, {31'd0, v.eb_byp});
        check($sformatf("v%0d rd_busy_nob", i), {31'd0, rd_busy_nob[0]}, {31'd0, v.eb_nob});
        @(posedge clk); #1;
        check($sformatf("v%0d busy_vec_byp", i), busy_vec_byp, v.e_vec);
        check($sformatf("v%0d busy_vec_nob", i), busy_vec_nob, v.e_vec);
    endtask

    initial begin
        //         w0    a0     d0            w1    a1     d1            iss   ia     fl    ra     e_byp         e_nob         ebb   ebn   e_vec
        vt[0]  = '{1'b1, 5'd7,  32'h11,       1'b1, 5'd7,  32'h22,       1'b0, 5'd0,  1'b0, 5'd7,  32'h22,       32'h0,        1'b0, 1'b0, 32'h0};
        vt[1]  = '{1'b1, 5'd8,  32'h33,       1'b1, 5'd10, 32'h44,       1'b0, 5'd0,  1'b0, 5'd7,  32'h22,       32'h22,       1'b0, 1'b0, 32'h0};
        vt[2]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 5'd8,  32'h33,       32'h33,       1'b0, 1'b0, 32'h0};
        vt[3]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 5'd10, 32'h44,       32'h44,       1'b0, 1'b0, 32'h0};
        vt[4]  = '{1'b1, 5'd3,  32'hA5A5,     1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 5'd3,  32'hA5A5,     32'h0,        1'b0, 1'b0, 32'h0};
        vt[5]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 5'd3,  32'hA5A5,     32'hA5A5,     1'b0, 1'b0, 32'h0};
        vt[6]  = '{1'b1, 5'd3,  32'h5A5A,     1'b1, 5'd3,  32'h1234,     1'b0, 5'd0,  1'b0, 5'd3,  32'h1234,     32'hA5A5,     1'b0, 1'b0, 32'h0};
        vt[7]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b1, 5'd0,  32'hFFFFFFFF, 1'b1, 5'd0,  1'b0, 5'd0,  32'h0,        32'h0,        1'b0, 1'b0, 32'h0};
        vt[8]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 5'd0,  32'h0,        32'h0,        1'b0, 1'b0, 32'h0};
        vt[9]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  1'b0, 5'd9,  32'h0,        32'h0,        1'b0, 1'b0, 32'h200};
        vt[10] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 5'd9,  32'h0,        32'h0,        1'b1, 1'b1, 32'h200};
        vt[11] = '{1'b1, 5'd9,  32'h99,       1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 5'd9,  32'h99,       32'h0,        1'b0, 1'b1, 32'h0};
        vt[12] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  32'h77,       1'b1, 5'd9,  1'b0, 5'd9,  32'h77,       32'h99,       1'b0, 1'b0, 32'h200};
        vt[13] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 5'd2,  1'b0, 5'd9,  32'h77,       32'h77,       1'b1, 1'b1, 32'h204};
        vt[14] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 5'd4,  1'b0, 5'd2,  32'h0,        32'h0,        1'b1, 1'b1, 32'h214};
        vt[15] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 5'd6,  1'b1, 5'd4,  32'h0,        32'h0,        1'b1, 1'b1, 32'h40};
        vt[16] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 5'd6,  32'h0,        32'h0,        1'b1, 1'b1, 32'h40};
        vt[17] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b1, 5'd6,  32'h0,        32'h0,        1'b1, 1'b1, 32'h0};

        // Reset: first edge clears everything, second holds a write that must not bypass.
        drive_idle();
        rst_n = 1'b0;
        rd_addr = {5'd3, 5'd2, 5'd1};
        @(posedge clk); #1;
        for (int k = 0; k < NUM_RD; k++) begin
            check($sformatf("reset rd_data_byp%0d", k), rd_data_byp[k*DW +: DW], 32'h0);
            check($sformatf("reset rd_data_nob%0d", k), rd_data_nob[k*DW +: DW], 32'h0);
        end
        check("reset busy_vec_byp", busy_vec_byp, 32'h0);
        wr1_en = 1'b1; wr1_addr = 5'd5; wr1_data = 32'h1;
        rd_addr = {10'd0, 5'd5};
        #2;
        check("reset no-bypass rd_data_byp", rd_data_byp[DW-1:0], 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive_idle();
        #2;
        check("reset r5 not written", rd_data_byp[DW-1:0], 32'h0);
        @(posedge clk); #1;

        for (int i = 0; i < NVEC; i++) run_vec(i, vt[i]);
        drive_idle();

        // All three read ports at once, with a wr1 bypass landing on port 1.
        rd_addr = {5'd10, 5'd8, 5'd7};
        wr1_en = 1'b1; wr1_addr = 5'd8; wr1_data = 32'hCAFE;
        exp_q.push_back(32'h22);
        exp_q.push_back(32'hCAFE);
        exp_q.push_back(32'h44);
        #2;
        for (int k = 0; k < NUM_RD; k++) begin
            logic [DW-1:0] e;
            e = exp_q.pop_front();
            check($sformatf("multiport rd_data_byp%0d", k), rd_data_byp[k*DW +: DW], e);
        end
        check("multiport rd_data_nob1", rd_data_nob[DW +: DW], 32'h33);
        @(posedge clk); #1;
        drive_idle();
        rd_addr = {10'd0, 5'd8};
        #2;
        check("multiport r8 stored", rd_data_nob[DW-1:0], 32'hCAFE);
        @(posedge clk); #1;

        // Preload r5 and mark it busy, then reset against competing flush/write/issue.
        wr0_en = 1'b1; wr0_addr = 5'd5; wr0_data = 32'hDEADBEEF;
        iss_en = 1'b1; iss_addr = 5'd5;
        @(posedge clk); #1;
        drive_idle();
        rd_addr = {10'd0, 5'd5};
        #2;
        check("preload r5", rd_data_nob[DW-1:0], 32'hDEADBEEF);
        check("preload busy_vec", busy_vec_byp, 32'h20);
        rst_n = 1'b0;
        flush = 1'b1;
        wr1_en = 1'b1; wr1_addr = 5'd5; wr1_data = 32'h1;
        iss_en = 1'b1; iss_addr = 5'd11;
        rd_addr = {5'd8, 5'd7, 5'd5};
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive_idle();
        rd_addr = {5'd8, 5'd7, 5'd5};
        #2;
        for (int k = 0; k < NUM_RD; k++) begin
            check($sformatf("clear rd_data_byp%0d", k), rd_data_byp[k*DW +: DW], 32'h0);
            check($sformatf("clear rd_data_nob%0d", k), rd_data_nob[k*DW +: DW], 32'h0);
        end
        check("clear busy_vec_byp", busy_vec_byp, 32'h0);
        check("clear busy_vec_nob", busy_vec_nob, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
